// File: rtl/niu32_io_ctrl.sv
// Memory-mapped board I/O block: HEX/LED output registers, debounced
// switch and key inputs with sticky key-press flags, one-cycle bus response.
module niu32_io_ctrl #(
   parameter int                   WORD_SIZE       = 32,
   parameter logic [WORD_SIZE-1:0] ADDR_HEX        = 32'hFFFF0000,
   parameter logic [WORD_SIZE-1:0] ADDR_LEDR       = 32'hFFFF0020,
   parameter logic [WORD_SIZE-1:0] ADDR_LEDG       = 32'hFFFF0040,
   parameter logic [WORD_SIZE-1:0] ADDR_KEY        = 32'hFFFF0100,
   parameter logic [WORD_SIZE-1:0] ADDR_SWITCH     = 32'hFFFF0120,
   parameter int                   DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] addr,
   input  logic [WORD_SIZE-1:0] wdata,
   input  logic                 wr,
   input  logic                 rd,
   output logic [WORD_SIZE-1:0] rdata,
   output logic                 ready,
   output logic                 hit,
   input  logic [3:0]           KEY,
   input  logic [9:0]           SWITCH,
   output logic [15:0]          hex_val,
   output logic [9:0]           LEDR,
   output logic [7:0]           LEDG
);

   localparam int NB = 14;
   localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
   // Keys idle high (not pressed), switches idle low.
   localparam logic [NB-1:0] IN_RST = {10'b0, 4'hF};

   typedef enum logic {IDLE, RESP} state_t;

   state_t state_q, state_d;

   logic [WORD_SIZE-1:0] rdata_q, rdata_d;
   logic [15:0] hex_q, hex_d;
   logic [9:0]  ledr_q, ledr_d;
   logic [7:0]  ledg_q, ledg_d;
   logic [3:0]  sticky_q, sticky_d;

   logic [NB-1:0] sync1_q, sync2_q;
   logic [NB-1:0] deb_q, deb_d;
   logic [CW-1:0] cnt_q [NB];
   logic [CW-1:0] cnt_d [NB];

   logic sel_hex, sel_ledr, sel_ledg, sel_key, sel_sw;
   logic accept;
   logic [3:0] pressed;
   logic [3:0] press_rise;
   logic [3:0] key_clr;
   logic unused_wdata;

   assign unused_wdata = ^wdata[WORD_SIZE-1:16];

   assign sel_hex  = (addr == ADDR_HEX);
   assign sel_ledr = (addr == ADDR_LEDR);
   assign sel_ledg = (addr == ADDR_LEDG);
   assign sel_key  = (addr == ADDR_KEY);
   assign sel_sw   = (addr == ADDR_SWITCH);
   assign hit = sel_hex | sel_ledr | sel_ledg | sel_key | sel_sw;

   assign accept = (state_q == IDLE) & (rd | wr) & hit;

   assign ready   = (state_q == RESP);
   assign rdata   = rdata_q;
   assign hex_val = hex_q;
   assign LEDR    = ledr_q;
   assign LEDG    = ledg_q;

   // Per-bit debounce: accept a new level only after it has been stable.
   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < NB; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CMAX) begin
            deb_d[i] = sync2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   assign pressed    = ~deb_q[3:0];
   assign press_rise = deb_q[3:0] & ~deb_d[3:0];
   assign key_clr    = (accept & wr & sel_key) ? wdata[7:4] : 4'b0;
   assign sticky_d   = (sticky_q & ~key_clr) | press_rise;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      hex_d   = hex_q;
      ledr_d  = ledr_q;
      ledg_d  = ledg_q;
      if (accept && wr) begin
         unique case (1'b1)
            sel_hex:  hex_d  = wdata[15:0];
            sel_ledr: ledr_d = wdata[9:0];
            sel_ledg: ledg_d = wdata[7:0];
            default:  ;
         endcase
         if (rd) rdata_d = '0;
      end else if (accept) begin
         unique case (1'b1)
            sel_hex:  rdata_d = WORD_SIZE'(hex_q);
            sel_ledr: rdata_d = WORD_SIZE'(ledr_q);
            sel_ledg: rdata_d = WORD_SIZE'(ledg_q);
            sel_sw:   rdata_d = WORD_SIZE'(deb_q[13:4]);
            sel_key:  rdata_d = WORD_SIZE'({sticky_q, pressed});
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         rdata_q  <= '0;
         hex_q    <= '0;
         ledr_q   <= '0;
         ledg_q   <= '0;
         sticky_q <= '0;
      end else begin
         state_q  <= state_d;
         rdata_q  <= rdata_d;
         hex_q    <= hex_d;
         ledr_q   <= ledr_d;
         ledg_q   <= ledg_d;
         sticky_q <= sticky_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= IN_RST;
         sync2_q <= IN_RST;
         deb_q   <= IN_RST;
         for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= {SWITCH, KEY};
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      end
   end

endmodule

// File: tb/tb_niu32_io_ctrl.sv
// Directed bench for niu32_io_ctrl: register writes/reads, debounce,
// sticky keys, unmapped accesses and reset during a response.
module tb_niu32_io_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr, wdata, rdata;
   logic        wr, rd, ready, hit;
   logic [3:0]  KEY;
   logic [9:0]  SWITCH;
   logic [15:0] hex_val;
   logic [9:0]  LEDR;
   logic [7:0]  LEDG;

   int pass_cnt = 0;
   int total_cnt = 0;

   niu32_io_ctrl dut (
      .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
      .wr(wr), .rd(rd), .rdata(rdata), .ready(ready), .hit(hit),
      .KEY(KEY), .SWITCH(SWITCH), .hex_val(hex_val),
      .LEDR(LEDR), .LEDG(LEDG)
   );

   always #5 clk = ~clk;

   // Issue one access from just after an edge; returns ready/rdata seen
   // just after the accepting edge, then lets the FSM return to IDLE.
   task automatic bus(input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic rdy, output logic [31:0] q);
      wr = w; rd = r; addr = a; wdata = d;
      @(posedge clk); #1;
      rdy = ready; q = rdata;
      wr = 1'b0; rd = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      logic rdy;
      logic [31:0] q;
      reset = 1'b0; wr = 1'b0; rd = 1'b0;
      addr = 32'hFFFF0000; wdata = '0;
      KEY = 4'hF; SWITCH = '0;
      #3;
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL rst_ready got %b want 0", ready);
      else pass_cnt++;
      total_cnt++;
      if (rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rdata);
      else pass_cnt++;
      total_cnt++;
      if ({hex_val, LEDR, LEDG} !== 34'h0)
         $display("FAIL rst_outs got %h want 0", {hex_val, LEDR, LEDG});
      else pass_cnt++;
      total_cnt++;
      if (hit !== 1'b1) $display("FAIL hit_hex got %b want 1", hit);
      else pass_cnt++;
      addr = 32'hFFFF0120; #1;
      total_cnt++;
      if (hit !== 1'b1) $display("FAIL hit_sw got %b want 1", hit);
      else pass_cnt++;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      bus(1'b0, 1'b1, 32'hFFFF0100, 32'h0, rdy, q);
      total_cnt++;
      if (rdy !== 1'b1 || q !== 32'h0)
         $display("FAIL first_req got rdy=%b q=%h want 1/0", rdy, q);
      else pass_cnt++;
   endtask

   task automatic test_ledr;
      logic rdy;
      logic [31:0] q;
      wr = 1'b1; addr = 32'hFFFF0020; wdata = 32'h3FF;
      @(posedge clk); #1;
      total_cnt++;
      if (ready !== 1'b1 || LEDR !== 10'h3FF)
         $display("FAIL ledr_wr got rdy=%b LEDR=%h want 1/3ff", ready, LEDR);
      else pass_cnt++;
      wr = 1'b0;
      @(posedge clk); #1;
      total_cnt++;
      if (ready !== 1'b0) $display("FAIL ledr_one_cycle got %b want 0", ready);
      else pass_cnt++;
      bus(1'b1, 1'b0, 32'hFFFF0020, 32'hABCDE2A5, rdy, q);
      bus(1'b0, 1'b1, 32'hFFFF0020, 32'h0, rdy, q);
      total_cnt++;
      if (LEDR !== 10'h2A5 || q !== 32'h2A5)
         $display("FAIL ledr_upper got LEDR=%h q=%h want 2a5", LEDR, q);
      else pass_cnt++;
   endtask

   task automatic test_hex;
      logic rdy;
      logic [31:0] q;
      bus(1'b1, 1'b0, 32'hFFFF0000, 32'hABCD1234, rdy, q);
      total_cnt++;
      if (hex_val !== 16'h1234) $display("FAIL hex_wr got %h want 1234", hex_val);
      else pass_cnt++;
      bus(1'b0, 1'b1, 32'hFFFF0000, 32'h0, rdy, q);
      total_cnt++;
      if (rdy !== 1'b1 || q !== 32'h00001234)
         $display("FAIL hex_rd got rdy=%b q=%h want 1/00001234", rdy, q);
      else pass_cnt++;
   endtask

   task automatic test_unmapped;
      int seen;
      seen = 0;
      rd = 1'b1; addr = 32'hFFFF0004; #1;
      total_cnt++;
      if (hit !== 1'b0) $display("FAIL unmapped_hit got %b want 0", hit);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b0) seen++;
      end
      rd = 1'b0;
      total_cnt++;
      if (seen != 0) $display("FAIL unmapped_ready got %0d pulses want 0", seen);
      else pass_cnt++;
      total_cnt++;
      if (rdata !== 32'h1234) $display("FAIL unmapped_rdata got %h want 1234", rdata);
      else pass_cnt++;
   endtask

   task automatic test_wr_rd_both;
      logic rdy;
      logic [31:0] q;
      bus(1'b1, 1'b1, 32'hFFFF0040, 32'h000001A5, rdy, q);
      total_cnt++;
      if (rdy !== 1'b1 || q !== 32'h0 || LEDG !== 8'hA5)
         $display("FAIL both got rdy=%b q=%h LEDG=%h want 1/0/a5", rdy, q, LEDG);
      else pass_cnt++;
   endtask

   task automatic test_switch;
      logic rdy;
      logic [31:0] q;
      SWITCH = 10'h155;
      repeat (20) @(posedge clk);
      #1;
      bus(1'b0, 1'b1, 32'hFFFF0120, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h155) $display("FAIL sw_read got %h want 155", q);
      else pass_cnt++;
      SWITCH[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      SWITCH[0] = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      bus(1'b0, 1'b1, 32'hFFFF0120, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h155) $display("FAIL sw_glitch got %h want 155", q);
      else pass_cnt++;
      bus(1'b1, 1'b0, 32'hFFFF0120, 32'h0, rdy, q);
      bus(1'b0, 1'b1, 32'hFFFF0120, 32'h0, rdy, q);
      total_cnt++;
      if (rdy !== 1'b1 || q !== 32'h155)
         $display("FAIL sw_wr_ignored got rdy=%b q=%h want 1/155", rdy, q);
      else pass_cnt++;
      // 2 sync edges + 16 stable edges: accepted at the 18th edge.
      SWITCH = 10'h2AA;
      repeat (17) @(posedge clk);
      #1;
      bus(1'b0, 1'b1, 32'hFFFF0120, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h155) $display("FAIL sw_early got %h want 155", q);
      else pass_cnt++;
      bus(1'b0, 1'b1, 32'hFFFF0120, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h2AA) $display("FAIL sw_settled got %h want 2aa", q);
      else pass_cnt++;
   endtask

   task automatic test_key;
      logic rdy;
      logic [31:0] q;
      KEY = 4'b1011;
      repeat (20) @(posedge clk);
      #1;
      bus(1'b0, 1'b1, 32'hFFFF0100, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h44) $display("FAIL key_held got %h want 44", q);
      else pass_cnt++;
      KEY = 4'hF;
      repeat (20) @(posedge clk);
      #1;
      bus(1'b0, 1'b1, 32'hFFFF0100, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h40) $display("FAIL key_sticky got %h want 40", q);
      else pass_cnt++;
      bus(1'b1, 1'b0, 32'hFFFF0100, 32'h30, rdy, q);
      bus(1'b0, 1'b1, 32'hFFFF0100, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h40) $display("FAIL key_clr_other got %h want 40", q);
      else pass_cnt++;
      bus(1'b1, 1'b0, 32'hFFFF0100, 32'h40, rdy, q);
      bus(1'b0, 1'b1, 32'hFFFF0100, 32'h0, rdy, q);
      total_cnt++;
      if (q !== 32'h0) $display("FAIL key_clr got %h want 0", q);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      logic rdy;
      logic [31:0] q;
      int seen;
      seen = 0;
      bus(1'b1, 1'b0, 32'hFFFF0040, 32'hFF, rdy, q);
      wr = 1'b1; addr = 32'hFFFF0020; wdata = 32'h155;
      @(posedge clk); #1;
      total_cnt++;
      if (ready !== 1'b1 || LEDG !== 8'hFF)
         $display("FAIL mid_pre got rdy=%b LEDG=%h want 1/ff", ready, LEDG);
      else pass_cnt++;
      reset = 1'b0; wr = 1'b0;
      #1;
      total_cnt++;
      if (ready !== 1'b0 || LEDG !== 8'h0 || LEDR !== 10'h0)
         $display("FAIL mid_rst got rdy=%b LEDG=%h LEDR=%h want 0/0/0",
                  ready, LEDG, LEDR);
      else pass_cnt++;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (ready !== 1'b0) seen++;
      end
      total_cnt++;
      if (seen != 0) $display("FAIL mid_no_pulse got %0d pulses want 0", seen);
      else pass_cnt++;
      bus(1'b0, 1'b1, 32'hFFFF0040, 32'h0, rdy, q);
      total_cnt++;
      if (rdy !== 1'b1 || q !== 32'h0)
         $display("FAIL mid_after got rdy=%b q=%h want 1/0", rdy, q);
      else pass_cnt++;
   endtask

   initial begin
      test_reset;
      test_ledr;
      test_hex;
      test_unmapped;
      test_wr_rd_both;
      test_switch;
      test_key;
      test_reset_mid;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/niu32_io_ctrl.md
NIU32_IO_CTRL -- requirements
Module: niu32_io_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WORD_SIZE, 32, bus data/address width
- ADDR_HEX, 32'hFFFF0000, hex display register
- ADDR_LEDR, 32'hFFFF0020, red LED register
- ADDR_LEDG, 32'hFFFF0040, green LED register
- ADDR_KEY, 32'hFFFF0100, key status register
- ADDR_SWITCH, 32'hFFFF0120, switch register
- DEBOUNCE_CYCLES, 16, stable cycles required before an input change is accepted

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge
- reset, in, 1, asynchronous, active-low reset
- addr, in, 32, CPU address
- wdata, in, 32, CPU write data
- wr, in, 1, write request
- rd, in, 1, read request
- rdata, out, 32, read data, valid while ready=1
- ready, out, 1, one-cycle completion strobe
- hit, out, 1, combinational: addr equals one of the five mapped addresses
- KEY, in, 4, raw board keys, active-low
- SWITCH, in, 10, raw board switches
- hex_val, out, 16, four hex digits for the seven-segment decoders
- LEDR, out, 10, red LEDs
- LEDG, out, 8, green LEDs

Function
REQ-003 The FSM SHALL have two states, IDLE and RESP; ready SHALL be 1 only in RESP.
REQ-004 Requests SHALL be accepted only in IDLE:
- In IDLE, (rd|wr)&hit at a rising edge accepts the request and moves the FSM to RESP.
- RESP SHALL return to IDLE unconditionally after one cycle.
- Latency from request to ready SHALL be exactly 1 cycle.
REQ-005 A request still asserted on return to IDLE SHALL be treated as a new request; the requester deasserts rd/wr in the cycle it samples ready=1.
REQ-006 Unmapped addresses: hit SHALL be 0, no state change, ready SHALL stay 0, and rdata SHALL be unchanged.
REQ-007 Writes SHALL update the target register at the accepting edge:
- HEX takes wdata[15:0], LEDR takes wdata[9:0], LEDG takes wdata[7:0].
- Upper bits SHALL be ignored.
- Writes to SWITCH SHALL have no effect.
REQ-008 If wr and rd are both asserted, the cycle SHALL be treated as a write, and rdata SHALL be loaded with 0.
REQ-009 On read, rdata SHALL be registered at the accepting edge and zero-extended to 32 bits:
- HEX: {16'b0, hex_val}
- LEDR and LEDG: the current register value
- SWITCH: debounced switches [9:0]
- KEY: {24'b0, sticky[3:0], pressed[3:0]}
REQ-010 Each KEY and SWITCH bit SHALL pass through a 2-flop synchronizer and then a per-bit debouncer:
- The counter increments while the synchronized value differs from the debounced value and clears when they match.
- When the counter reaches DEBOUNCE_CYCLES-1, the debounced value SHALL take the synchronized value and the counter SHALL clear.
REQ-011 pressed[i] SHALL be the inverse of debounced KEY[i], so 1 means pressed.
REQ-012 sticky[i] SHALL set on a 0->1 transition of pressed[i].
REQ-013 A write to ADDR_KEY SHALL clear each sticky[i] whose wdata[4+i]=1.
REQ-014 If a set and a clear of sticky[i] occur in the same cycle, set SHALL win.
REQ-015 The debounce, synchronizer and sticky logic SHALL run every cycle, independent of the FSM state.
REQ-016 hex_val, LEDR and LEDG SHALL be driven directly from their registers.

Reset
REQ-017 While reset=0, all of the following SHALL hold asynchronously:
- FSM=IDLE, ready=0, rdata=0
- hex_val=0, LEDR=0, LEDG=0
- sticky=0, debounce counters=0
- synchronizers and debounced KEY all 1 (not pressed), debounced SWITCH all 0
REQ-018 Reset asserted during RESP SHALL abort the transaction with no further ready pulse.
REQ-019 After reset deasserts, the first request SHALL be accepted at the first rising edge.

Verification
REQ-020 The bench SHALL cover at least these scenarios:
- wr=1, addr=FFFF0020, wdata=32'h3FF -> LEDR=10'h3FF one edge later, ready=1 for exactly one cycle.
- rd=1, addr=FFFF0000 after writing 32'hABCD1234 -> rdata=32'h00001234 with ready=1.
- Hold SWITCH=10'h155 for 20 cycles, then read FFFF0120 -> rdata=32'h155; a 5-cycle glitch on SWITCH[0] -> value unchanged.
- Hold KEY[2]=0 for 20 cycles, release, then read FFFF0100 -> rdata=32'h40; write wdata=32'h40 -> next read returns 32'h0.
- rd=1, addr=FFFF0004 -> hit=0, ready stays 0 for 5 cycles.
- Assert reset=0 mid-RESP with LEDG=8'hFF -> ready=0 and LEDG=0 immediately, no ready pulse after release.
